fft_stream_sorter: RTL and testbench

- Streaming reorder buffer placed after the fft core in the audio spectrum path.
- Accepts complex samples one per cycle in arrival order and groups them into N-point frames.
- Emits each frame one sample per cycle, either in bit-reversed address order or in natural order, with a valid/ready handshake.
- Ping-pong banks let one frame be written while the previous one is read. This replaces the flat-bus combinational sorter for streaming use.

---
 rtl/fft_pkg.sv | 48 ++++
 rtl/fft_stream_sorter_if.sv | 28 ++
 rtl/fft_bank_ram.sv | 29 ++
 rtl/fft_stream_sorter.sv | 156 +++++++++++++++
 tb/tb_fft_stream_sorter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared constants and helper functions for the fft datapath blocks
// (fft core, fft_sorter and the streaming reorder buffer).
package fft_pkg;

    // Largest supported frame is 1024 points, so indices never exceed 10 bits.
    localparam int FFT_MAX_AW = 10;

    // Ceiling log2, used to size frame indices from the point count.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // A complex sample packs real and imaginary parts side by side.
    function automatic int cplx_width(input int data_width);
        return 2 * data_width;
    endfunction

    // Reverse the low 'width' bits of value; the result is right-aligned.
    function automatic logic [FFT_MAX_AW-1:0] bit_reverse(
        input logic [FFT_MAX_AW-1:0] value,
        input int                    width
    );
        logic [FFT_MAX_AW-1:0] v;
        logic [FFT_MAX_AW-1:0] r;
        v = value;
        r = {FFT_MAX_AW{1'b0}};
        for (int i = 0; i < FFT_MAX_AW; i++) begin
            if (i < width) begin
                r = {r[FFT_MAX_AW-2:0], v[0]};
                v = {1'b0, v[FFT_MAX_AW-1:1]};
            end else begin
                r = r;
                v = v;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_stream_sorter_if.sv
// Sample-in / sample-out handshake bundle of the streaming reorder buffer.
interface fft_stream_sorter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = 4
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_re;
    logic signed [DATA_WIDTH-1:0] in_im;
    logic                         out_valid;
    logic                         out_ready;
    logic        [DATA_WIDTH-1:0] out_re;
    logic        [DATA_WIDTH-1:0] out_im;
    logic        [IDX_W-1:0]      out_index;
    logic                         out_last;

    // Environment side: produces input samples, consumes output samples.
    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_index, out_last
    );

    // Sorter side.
    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_index, out_last
    );
endinterface

// File: rtl/fft_bank_ram.sv
// Two-bank frame store: address {bank, index}, synchronous write,
// combinational read (the caller registers the read data).
module fft_bank_ram
    import fft_pkg::*;
#(
    parameter  int N     = 16,
    parameter  int WIDTH = 32,
    localparam int AW    = clog2(N)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW:0]      i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW:0]      i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [0:2*N-1];

    // Sample write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fft_stream_sorter.sv
// Streaming ping-pong reorder buffer: collects N-point frames in arrival
// order and replays each one in natural or bit-reversed order.
module fft_stream_sorter
    import fft_pkg::*;
#(
    parameter int N          = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              en,
    input  logic              flush,
    input  logic              bitrev,
    fft_stream_sorter_if.slave bus
);

    localparam int              AW       = clog2(N);
    localparam int              CW       = cplx_width(DATA_WIDTH);
    localparam logic [AW-1:0]   LAST_IDX = AW'(N - 1);

    logic [AW-1:0]         r_wr_cnt;
    logic [AW-1:0]         r_rd_cnt;
    logic                  r_wr_bank;
    logic                  r_rd_bank;
    logic [1:0]            r_bank_full;
    logic                  r_frame_mode;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [AW-1:0]         r_out_index;
    logic [DATA_WIDTH-1:0] r_out_re;
    logic [DATA_WIDTH-1:0] r_out_im;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_wr_last;
    logic                  w_rd_last;
    logic                  w_mode;
    logic [AW-1:0]         w_rd_idx;
    logic [1:0]            w_set_mask;
    logic [1:0]            w_clr_mask;
    logic [1:0]            w_bank_full_nxt;
    logic [CW-1:0]         w_rd_data;

    // Handshake qualifiers, bank occupancy update and read-address selection
    always_comb begin
        w_in_ready = en & ~flush & ~r_bank_full[r_wr_bank];
        w_accept   = bus.in_valid & w_in_ready;
        w_load     = en & ~flush & r_bank_full[r_rd_bank] & (~r_out_valid | bus.out_ready);
        w_wr_last  = (r_wr_cnt == LAST_IDX);
        w_rd_last  = (r_rd_cnt == LAST_IDX);
        // Set and clear never target the same bank, so masks can be combined freely.
        w_set_mask      = (w_accept & w_wr_last) ? (2'b01 << r_wr_bank) : 2'b00;
        w_clr_mask      = (w_load & w_rd_last) ? (2'b01 << r_rd_bank) : 2'b00;
        w_bank_full_nxt = (r_bank_full | w_set_mask) & ~w_clr_mask;
        if (r_rd_cnt == {AW{1'b0}}) begin
            w_mode = bitrev;
        end else begin
            w_mode = r_frame_mode;
        end
        if (w_mode) begin
            w_rd_idx = AW'(bit_reverse(FFT_MAX_AW'(r_rd_cnt), AW));
        end else begin
            w_rd_idx = r_rd_cnt;
        end
    end

    fft_bank_ram #(
        .N     (N),
        .WIDTH (CW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr ({r_wr_bank, r_wr_cnt}),
        .i_wdata ({bus.in_re, bus.in_im}),
        .i_raddr ({r_rd_bank, w_rd_idx}),
        .o_rdata (w_rd_data)
    );

    // Write/read frame counters, bank pointers and bank occupancy
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_cnt     <= {AW{1'b0}};
            r_rd_cnt     <= {AW{1'b0}};
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_bank_full  <= 2'b00;
            r_frame_mode <= 1'b0;
        end else if (en) begin
            if (flush) begin
                r_wr_cnt     <= {AW{1'b0}};
                r_rd_cnt     <= {AW{1'b0}};
                r_wr_bank    <= 1'b0;
                r_rd_bank    <= 1'b0;
                r_bank_full  <= 2'b00;
                r_frame_mode <= 1'b0;
            end else begin
                if (w_accept) begin
                    if (w_wr_last) begin
                        r_wr_cnt  <= {AW{1'b0}};
                        r_wr_bank <= ~r_wr_bank;
                    end else begin
                        r_wr_cnt <= r_wr_cnt + 1'b1;
                    end
                end
                if (w_load) begin
                    r_frame_mode <= w_mode;
                    if (w_rd_last) begin
                        r_rd_cnt  <= {AW{1'b0}};
                        r_rd_bank <= ~r_rd_bank;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                    end
                end
                r_bank_full <= w_bank_full_nxt;
            end
        end
    end

    // Registered output stage; holds its contents while downstream stalls
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_index <= {AW{1'b0}};
            r_out_re    <= {DATA_WIDTH{1'b0}};
            r_out_im    <= {DATA_WIDTH{1'b0}};
        end else if (en) begin
            if (flush) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_out_index <= {AW{1'b0}};
                r_out_re    <= {DATA_WIDTH{1'b0}};
                r_out_im    <= {DATA_WIDTH{1'b0}};
            end else if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_last  <= w_rd_last;
                r_out_index <= r_rd_cnt;
                r_out_re    <= w_rd_data[CW-1:DATA_WIDTH];
                r_out_im    <= w_rd_data[DATA_WIDTH-1:0];
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.out_index = r_out_index;
    assign bus.out_re    = r_out_re;
    assign bus.out_im    = r_out_im;

endmodule

// File: tb/tb_fft_stream_sorter.sv
// Bench for fft_stream_sorter: frame-queue reference model checked every
// cycle, plus table and hand-written sequences for the corner cases.
module tb_fft_stream_sorter;

    localparam int N  = 16;
    localparam int DW = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic n_rst;
    logic en;
    logic flush;
    logic bitrev;

    always #5 clk = ~clk;

    fft_stream_sorter_if #(.DATA_WIDTH(DW), .IDX_W(AW)) ifc ();

    fft_stream_sorter #(.N(N), .DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .en     (en),
        .flush  (flush),
        .bitrev (bitrev),
        .bus    (ifc)
    );

    typedef struct { bit br; int exp_re; bit exp_last; } vec_t;
    typedef struct { int re; int im; int idx; bit last; int cyc; } obs_t;

    vec_t        tbl [2*N];
    obs_t        cap [$];
    int          seq [N];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          last_acc;
    int          send_ticks;

    // reference model: complete frames waiting/being read, and the partial one
    logic [31:0] fq   [$];
    logic [31:0] part [$];
    bit          m_valid, m_zero, m_last, m_mode;
    int          m_re, m_im, m_idx, m_pos;

    task automatic chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rev(int v);
        int r;
        r = 0;
        for (int i = 0; i < AW; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    task automatic model_clear();
        fq.delete();
        part.delete();
        m_valid = 1'b0; m_zero = 1'b1; m_last = 1'b0; m_mode = 1'b0;
        m_re = 0; m_im = 0; m_idx = 0; m_pos = 0;
    endtask

    // Compare DUT against the model just before an edge, then advance the model.
    task automatic check_cycle();
        bit          exp_rdy;
        bit          ld;
        int          a;
        logic [31:0] s;
        obs_t        o;
        if (!n_rst) model_clear();
        exp_rdy = en && !flush && (fq.size() < 2*N);
        chk("in_ready", 32'(ifc.in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(ifc.out_valid), 32'(m_valid));
        if (m_valid || m_zero) begin
            chk("out_re", 32'($signed(ifc.out_re)), m_re);
            chk("out_im", 32'($signed(ifc.out_im)), m_im);
            chk("out_index", 32'(ifc.out_index), m_idx);
            chk("out_last", 32'(ifc.out_last), 32'(m_last));
        end
        last_acc = n_rst && exp_rdy && ifc.in_valid;
        if (n_rst && en && !flush && ifc.out_valid && ifc.out_ready) begin
            o.re = 32'($signed(ifc.out_re)); o.im = 32'($signed(ifc.out_im));
            o.idx = 32'(ifc.out_index); o.last = ifc.out_last; o.cyc = cyc;
            cap.push_back(o);
        end
        if (n_rst && en) begin
            if (flush) begin
                model_clear();
            end else begin
                ld = (fq.size() >= N) && (!m_valid || ifc.out_ready);
                if (ld) begin
                    if (m_pos == 0) m_mode = bitrev;
                    a = m_mode ? rev(m_pos) : m_pos;
                    s = fq[a];
                    m_re = 32'($signed(s[31:16]));
                    m_im = 32'($signed(s[15:0]));
                    m_idx = m_pos; m_last = (m_pos == N-1);
                    m_valid = 1'b1; m_zero = 1'b0;
                    m_pos++;
                    if (m_pos == N) begin
                        m_pos = 0;
                        repeat (N) void'(fq.pop_front());
                    end
                end else if (ifc.out_ready) begin
                    m_valid = 1'b0;
                end
                if (last_acc) begin
                    part.push_back({ifc.in_re, ifc.in_im});
                    if (part.size() == N) begin
                        foreach (part[i]) fq.push_back(part[i]);
                        part.delete();
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(int re, int im);
        ifc.in_valid = 1'b1;
        ifc.in_re    = 16'(re);
        ifc.in_im    = 16'(im);
        last_acc     = 1'b0;
        send_ticks   = 0;
        while (!last_acc && send_ticks < 300) begin
            tick();
            send_ticks++;
        end
        if (!last_acc) chk("send_accept", 32'(last_acc), 1);
    endtask

    task automatic drain(int n);
        ifc.in_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int stalls, gaps, w, sent, guard, hold_idx;

        seq = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        for (int j = 0; j < N; j++) begin
            tbl[j].br = 1'b1;   tbl[j].exp_re = seq[j]; tbl[j].exp_last = (j == N-1);
            tbl[N+j].br = 1'b0; tbl[N+j].exp_re = j;    tbl[N+j].exp_last = (j == N-1);
        end

        n_rst = 1'b0; en = 1'b1; flush = 1'b0; bitrev = 1'b1;
        ifc.in_valid = 1'b0; ifc.in_re = 16'sd0; ifc.in_im = 16'sd0; ifc.out_ready = 1'b1;
        model_clear();
        repeat (2) tick();
        n_rst = 1'b1;
        chk("rst_out_valid", 32'(ifc.out_valid), 0);
        chk("rst_out_index", 32'(ifc.out_index), 0);
        chk("rst_out_re", 32'(ifc.out_re), 0);
        chk("rst_in_ready", 32'(ifc.in_ready), 1);

        // bit-reversed then natural frame, expected sequences from the table
        for (int f = 0; f < 2; f++) begin
            bitrev = tbl[f*N].br;
            cap.delete();
            for (int k = 0; k < N; k++) send(k, -k);
            ifc.in_valid = 1'b0;
            chk("latency_pre", 32'(ifc.out_valid), 0);
            tick();
            chk("latency_first", 32'(ifc.out_valid), 1);
            chk("latency_first_idx", 32'(ifc.out_index), 0);
            drain(N + 4);
            chk("tbl_len", cap.size(), N);
            for (int j = 0; j < N && j < cap.size(); j++) begin
                chk("tbl_re", cap[j].re, tbl[f*N+j].exp_re);
                chk("tbl_im", cap[j].im, -tbl[f*N+j].exp_re);
                chk("tbl_idx", cap[j].idx, j);
                chk("tbl_last", 32'(cap[j].last), 32'(tbl[f*N+j].exp_last));
            end
        end

        // back-to-back frames without bubbles
        bitrev = 1'b0; cap.delete(); stalls = 0; gaps = 0;
        for (int k = 0; k < 3*N; k++) begin
            send(1000 + k, k);
            stalls += send_ticks - 1;
        end
        drain(N + 4);
        chk("stream_stalls", stalls, 0);
        chk("stream_len", cap.size(), 3*N);
        for (int i = 1; i < cap.size(); i++) if (cap[i].cyc != cap[i-1].cyc + 1) gaps++;
        chk("stream_gaps", gaps, 0);

        // both banks fill while downstream is stalled
        cap.delete();
        ifc.out_ready = 1'b0;
        for (int k = 0; k < 2*N; k++) send(2000 + k, -k);
        chk("full_in_ready", 32'(ifc.in_ready), 0);
        drain(3);
        chk("full_in_ready_hold", 32'(ifc.in_ready), 0);
        ifc.out_ready = 1'b1;
        w = 0;
        while (!ifc.in_ready && w < 100) begin
            tick();
            w++;
        end
        chk("refill_wait", w, N - 1);
        chk("refill_last", 32'(ifc.out_last), 1);
        chk("refill_idx", 32'(ifc.out_index), N - 1);
        drain(2*N + 4);
        chk("held_frames_len", cap.size(), 2*N);

        // random stalls and random bitrev over 10 frames
        cap.delete(); sent = 0; guard = 0;
        while (sent < 10*N && guard < 5000) begin
            ifc.in_valid  = ($urandom_range(0, 3) != 0);
            ifc.in_re     = 16'($urandom);
            ifc.in_im     = 16'($urandom);
            ifc.out_ready = 1'($urandom_range(0, 1));
            bitrev        = 1'($urandom_range(0, 1));
            tick();
            if (last_acc) sent++;
            guard++;
        end
        chk("rand_sent", sent, 10*N);
        ifc.out_ready = 1'b1;
        drain(2*N + 4);
        chk("rand_out_count", cap.size(), 10*N);

        // partial frame discarded by flush
        bitrev = 1'b1; cap.delete();
        for (int k = 0; k < 7; k++) send(50 + k, 0);
        ifc.in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < N; k++) send(100 + k, -(100 + k));
        drain(N + 4);
        chk("flush_len", cap.size(), N);
        for (int j = 0; j < N && j < cap.size(); j++) chk("flush_re", cap[j].re, 100 + seq[j]);

        // asynchronous reset while a frame is being emitted
        for (int k = 0; k < N; k++) send(300 + k, k);
        ifc.in_valid = 1'b0;
        repeat (6) tick();
        n_rst = 1'b0;
        #1;
        chk("arst_valid", 32'(ifc.out_valid), 0);
        chk("arst_re", 32'(ifc.out_re), 0);
        chk("arst_im", 32'(ifc.out_im), 0);
        chk("arst_idx", 32'(ifc.out_index), 0);
        chk("arst_last", 32'(ifc.out_last), 0);
        repeat (2) tick();
        n_rst = 1'b1;
        cap.delete(); bitrev = 1'b0;
        for (int k = 0; k < N; k++) send(400 + k, k);
        drain(N + 4);
        chk("arst_next_len", cap.size(), N);
        for (int j = 0; j < N && j < cap.size(); j++) chk("arst_next_re", cap[j].re, 400 + j);

        // bitrev change mid-frame and an enable pause
        bitrev = 1'b0; cap.delete();
        for (int k = 0; k < N; k++) send(500 + k, k);
        for (int k = 0; k < N; k++) begin
            send(600 + k, k);
            if (k == 4) bitrev = 1'b1;
            if (k == 8) begin
                hold_idx = 32'(ifc.out_index);
                en = 1'b0;
                repeat (3) begin
                    tick();
                    chk("en_low_ready", 32'(ifc.in_ready), 0);
                    chk("en_low_idx_hold", 32'(ifc.out_index), hold_idx);
                end
                en = 1'b1;
            end
        end
        drain(2*N + 4);
        chk("mode_len", cap.size(), 2*N);
        for (int j = 0; j < N && 2*N <= cap.size(); j++) begin
            chk("mode_keep_re", cap[j].re, 500 + j);
            chk("mode_next_re", cap[N+j].re, 600 + seq[j]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
